vga_timing: RTL and testbench
=============================

# vga_timing

Free-running SVGA raster timing generator; produces the `hcount`/`vcount`/sync/blanking stream that every downstream drawing stage consumes (background, rectangle/sprite overlay, etc.). It sits at the head of the video pipeline, clocked by the pixel clock. Default parameters give 800x600 @ 60 Hz with a 40 MHz `pclk`. All outputs describe the same pixel in the same cycle.

## Interface
- `H_VISIBLE`, 800: visible pixels per line
- `H_FP`, 40: horizontal front porch (pixels)
- `H_SYNC`, 128: hsync width (pixels)
- `H_BP`, 88: horizontal back porch (pixels); H_TOTAL = sum = 1056
- `V_VISIBLE`, 600: visible lines per frame
- `V_FP`, 1: vertical front porch (lines)
- `V_SYNC`, 4: vsync width (lines)
- `V_BP`, 23: vertical back porch (lines); V_TOTAL = sum = 628
- `SYNC_POL`, 1: active level of both hsync and vsync (1 = active high)

- `pclk`  in  1  pixel clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `hcount`  out  11  horizontal pixel index, 0..H_TOTAL-1
- `hsync`  out  1  horizontal sync, level per SYNC_POL
- `hblnk`  out  1  horizontal blanking, active high
- `vcount`  out  11  vertical line index, 0..V_TOTAL-1
- `vsync`  out  1  vertical sync, level per SYNC_POL
- `vblnk`  out  1  vertical blanking, active high
- `frame_start`  out  1  (only with macro) one-cycle pulse at frame wrap
- `frame_cnt`  out  16  (only with macro) completed-frame counter

## Operation
- `hcount`, `vcount` are registers driven directly to the outputs; flags are registered and decoded from the *next* count values, so flags align with counts (no skew).
- `hcount` increments every cycle; at H_TOTAL-1 it wraps to 0 and `vcount` increments.
- `vcount` wraps to 0 only when `hcount` wraps and `vcount` = V_TOTAL-1 (both return to 0 on the same edge).
- `hblnk` = 1 iff `hcount` >= H_VISIBLE (800..1055).
- `hsync` active iff H_VISIBLE+H_FP <= `hcount` < H_VISIBLE+H_FP+H_SYNC (840..967).
- `vblnk` = 1 iff `vcount` >= V_VISIBLE (600..627).
- `vsync` active iff V_VISIBLE+V_FP <= `vcount` < V_VISIBLE+V_FP+V_SYNC (601..604), for whole lines (changes only coincident with `hcount` wrap to 0).
- Comparisons are unsigned 11-bit; parameter sums must fit 11 bits (max 2047), checked at elaboration.
- Reset: `hcount`=0, `vcount`=0, `hblnk`=0, `vblnk`=0, `hsync`=`vsync`=inactive level (~SYNC_POL), `frame_start`=0, `frame_cnt`=0. Reset mid-frame abandons the frame immediately; outputs hold pixel (0,0) values while `rst` is high.

## Timing
- First rising edge with `rst` low: `hcount` 0->1; (0,0) is held for every reset cycle plus one.
- Line period H_TOTAL cycles (1056); frame period H_TOTAL*V_TOTAL cycles (663168).
- Sync/blank flag latency relative to counts: 0 cycles.
- No input handshake; block never stalls.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: `frame_start` and `frame_cnt` ports exist. `frame_start` = 1 for exactly the one cycle in which outputs show (0,0) reached by wrap from (H_TOTAL-1, V_TOTAL-1); not asserted for the post-reset (0,0). `frame_cnt` increments on that same edge, wraps 0xFFFF->0x0000, reset 0.
- Not defined: neither port nor their registers exist; all other behaviour identical.

## Test plan
- Reset held 5 cycles, then released -> (0,0), hsync/vsync=0, blnk=0 during reset and first released cycle; `hcount`=1 on the next.
- Run one line -> `hblnk` rises at `hcount`=800, `hsync` high exactly for 840..967 (128 cycles), `hcount` wraps 1055->0 with `vcount` 0->1.
- Run one frame -> `vblnk` high for lines 600..627, `vsync` high for lines 601..604 (4*1056 cycles), (1055,627)->(0,0) on one edge; frame period 663168 cycles.
- With `VGA_TIMING_FRAME_CNT_EN`: 3 frames -> `frame_start` pulses 3 times, one cycle each, `frame_cnt`=3; none after reset release; force `frame_cnt`=0xFFFF -> next wrap gives 0.
- Assert `rst` at (500,300) for 1 cycle -> next cycle outputs (0,0) with reset flag values; counting restarts cleanly.
- SYNC_POL=0 -> sync outputs inverted (idle/reset 1, low during 840..967 / 601..604); blanking unchanged.

Source files
------------

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Free-running raster timing generator for the head of the video pipeline.
// Produces horizontal/vertical pixel counters together with sync and
// blanking flags that all describe the same pixel in the same cycle.
// Defaults give 800x600 @ 60 Hz from a 40 MHz pixel clock.
//
// Ports
//   pclk         in   pixel clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   hcount[10:0] out  horizontal pixel index, 0..H_TOTAL-1
//   hsync        out  horizontal sync, active level = SYNC_POL
//   hblnk        out  horizontal blanking, active high
//   vcount[10:0] out  vertical line index, 0..V_TOTAL-1
//   vsync        out  vertical sync, active level = SYNC_POL
//   vblnk        out  vertical blanking, active high
//   frame_start  out  one-cycle pulse on the (0,0) reached by frame wrap
//   frame_cnt    out  count of completed frames, wraps at 16 bits
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//   When defined, frame_start and frame_cnt (and their registers) exist.
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter bit          SYNC_POL  = 1'b1
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic        frame_start,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // All counters and comparisons are 11 bits wide, so every boundary
    // derived from the parameters has to fit in that range.
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_param_check
        $error("vga_timing: H_TOTAL and V_TOTAL must fit in 11 bits");
    end

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic        SYNC_ACT   = SYNC_POL;

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_hblnk;
    logic        r_vsync;
    logic        r_vblnk;

    logic        w_hwrap;
    logic        w_vwrap;
    logic [10:0] w_hnext;
    logic [10:0] w_vnext;

    // Next-count values. Flags are decoded from these rather than from the
    // current counts so that registered flags land in the same cycle as the
    // counts they describe. vcount only moves when hcount wraps, which keeps
    // vsync/vblnk changing on whole-line boundaries.
    always_comb begin
        w_hwrap = (r_hcount == H_LAST);
        w_vwrap = (r_vcount == V_LAST);
        w_hnext = w_hwrap ? 11'd0 : r_hcount + 11'd1;
        w_vnext = r_vcount;
        if (w_hwrap) begin
            w_vnext = w_vwrap ? 11'd0 : r_vcount + 11'd1;
        end
    end

    // Reset values coincide with the decode of pixel (0,0), so the post-reset
    // pixel and a wrapped (0,0) look identical apart from frame_start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hcount <= 11'd0;
            r_vcount <= 11'd0;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_hsync  <= ~SYNC_ACT;
            r_vsync  <= ~SYNC_ACT;
        end else begin
            r_hcount <= w_hnext;
            r_vcount <= w_vnext;
            r_hblnk  <= (w_hnext >= H_VIS);
            r_vblnk  <= (w_vnext >= V_VIS);
            r_hsync  <= ((w_hnext >= HS_START) && (w_hnext < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
            r_vsync  <= ((w_vnext >= VS_START) && (w_vnext < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    assign hcount = r_hcount;
    assign vcount = r_vcount;
    assign hsync  = r_hsync;
    assign hblnk  = r_hblnk;
    assign vsync  = r_vsync;
    assign vblnk  = r_vblnk;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic        r_frame_start;
    logic [15:0] r_frame_cnt;

    // A frame completes only on the wrap from the last pixel of the last
    // line; the (0,0) produced by reset release never raises frame_start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_frame_start <= w_hwrap & w_vwrap;
            if (w_hwrap && w_vwrap) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
// Self-checking bench for vga_timing. Three instances share clock and reset:
//   u_sm  small raster (32x14 total), SYNC_POL=1 - frame-level behaviour
//   u_p0  same small raster with SYNC_POL=0     - inverted sync levels
//   u_df  default 800x600 timing                - full-size line behaviour
// Every cycle the bench model computes the expected pixel state, pushes it
// to a queue, and the calling test pops and compares it against the DUTs.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    localparam int S_HV = 16, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VV = 8,  S_VF = 1, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int D_HT = 1056;
    localparam int D_VT = 628;

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam int SMW = 43;
`else
    localparam int SMW = 26;
`endif

    typedef struct packed {
        logic [SMW-1:0] sm;
        logic [25:0]    p0;
        logic [25:0]    df;
    } exp_t;

    logic        pclk;
    logic        rst;
    logic [10:0] sm_hcount, sm_vcount, p0_hcount, p0_vcount, df_hcount, df_vcount;
    logic        sm_hsync, sm_hblnk, sm_vsync, sm_vblnk;
    logic        p0_hsync, p0_hblnk, p0_vsync, p0_vblnk;
    logic        df_hsync, df_hblnk, df_vsync, df_vblnk;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic        sm_fs, p0_fs, df_fs;
    logic [15:0] sm_fc, p0_fc, df_fc;
    logic        mfs;
    logic [15:0] mfc;
`endif

    logic [SMW-1:0] obs_sm;
    logic [25:0]    obs_p0;
    logic [25:0]    obs_df;

    exp_t sbq[$];
    int   total;
    int   bad;
    int   mh, mv, dh, dv;

    vga_timing #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b1)
    ) u_sm (
        .pclk(pclk), .rst(rst),
        .hcount(sm_hcount), .hsync(sm_hsync), .hblnk(sm_hblnk),
        .vcount(sm_vcount), .vsync(sm_vsync), .vblnk(sm_vblnk)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_start(sm_fs), .frame_cnt(sm_fc)
`endif
    );

    vga_timing #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b0)
    ) u_p0 (
        .pclk(pclk), .rst(rst),
        .hcount(p0_hcount), .hsync(p0_hsync), .hblnk(p0_hblnk),
        .vcount(p0_vcount), .vsync(p0_vsync), .vblnk(p0_vblnk)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_start(p0_fs), .frame_cnt(p0_fc)
`endif
    );

    vga_timing u_df (
        .pclk(pclk), .rst(rst),
        .hcount(df_hcount), .hsync(df_hsync), .hblnk(df_hblnk),
        .vcount(df_vcount), .vsync(df_vsync), .vblnk(df_vblnk)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_start(df_fs), .frame_cnt(df_fc)
`endif
    );

`ifdef VGA_TIMING_FRAME_CNT_EN
    assign obs_sm = {sm_hcount, sm_vcount, sm_hsync, sm_hblnk, sm_vsync, sm_vblnk, sm_fs, sm_fc};
`else
    assign obs_sm = {sm_hcount, sm_vcount, sm_hsync, sm_hblnk, sm_vsync, sm_vblnk};
`endif
    assign obs_p0 = {p0_hcount, p0_vcount, p0_hsync, p0_hblnk, p0_vsync, p0_vblnk};
    assign obs_df = {df_hcount, df_vcount, df_hsync, df_hblnk, df_vsync, df_vblnk};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Expected outputs for a pixel position, straight from the raster ranges.
    function automatic logic [25:0] pack_exp(input int h, input int v,
                                             input int hv, input int hf, input int hs,
                                             input int vv, input int vf, input int vs,
                                             input bit pol);
        logic hact, vact, hlvl, vlvl, hb, vb;
        hact = (h >= hv + hf) && (h < hv + hf + hs);
        vact = (v >= vv + vf) && (v < vv + vf + vs);
        hlvl = pol ? hact : !hact;
        vlvl = pol ? vact : !vact;
        hb   = (h >= hv);
        vb   = (v >= vv);
        return {11'(h), 11'(v), hlvl, hb, vlvl, vb};
    endfunction

    // Drive one clock with the given reset level, advance the model and push
    // the expected state; returns at the following falling edge.
    task automatic drive_cycle(input logic r);
        exp_t e;
        rst = r;
        @(posedge pclk);
        if (r) begin
            mh = 0; mv = 0; dh = 0; dv = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            mfs = 1'b0; mfc = 16'd0;
`endif
        end else begin
`ifdef VGA_TIMING_FRAME_CNT_EN
            mfs = 1'b0;
`endif
            if (mh == S_HT - 1) begin
                mh = 0;
                if (mv == S_VT - 1) begin
                    mv = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
                    mfs = 1'b1;
                    mfc = mfc + 16'd1;
`endif
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
            if (dh == D_HT - 1) begin
                dh = 0;
                dv = (dv == D_VT - 1) ? 0 : dv + 1;
            end else begin
                dh = dh + 1;
            end
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.sm = {pack_exp(mh, mv, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS, 1'b1), mfs, mfc};
`else
        e.sm = pack_exp(mh, mv, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS, 1'b1);
`endif
        e.p0 = pack_exp(mh, mv, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS, 1'b0);
        e.df = pack_exp(dh, dv, 800, 40, 128, 600, 1, 4, 1'b1);
        sbq.push_back(e);
        @(negedge pclk);
    endtask

    task automatic test_reset;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL reset_hold got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
        end
        drive_cycle(1'b0);
        e = sbq.pop_front();
        total++;
        if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
            bad++;
            $display("[TB] FAIL reset_release got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
        end
        total++;
        if (sm_hcount !== 11'd1 || df_hcount !== 11'd1) begin
            bad++;
            $display("[TB] FAIL first_count got=%0d/%0d exp=1", sm_hcount, df_hcount);
        end
    endtask

    task automatic test_line;
        exp_t e;
        int   hs_cnt;
        int   wraps;
        logic [10:0] ph, pv;
        logic pb;
        hs_cnt = 0;
        wraps  = 0;
        for (int i = 0; i < D_HT; i++) begin
            ph = df_hcount; pv = df_vcount; pb = df_hblnk;
            drive_cycle(1'b0);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL line_scan got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
            if (df_vcount == 11'd0 && df_hsync) hs_cnt++;
            if (!pb && df_hblnk) begin
                total++;
                if (df_hcount !== 11'd800) begin
                    bad++;
                    $display("[TB] FAIL hblnk_rise got=%0d exp=800", df_hcount);
                end
            end
            if (ph == 11'(D_HT - 1)) begin
                wraps++;
                total++;
                if (df_hcount !== 11'd0 || df_vcount !== pv + 11'd1) begin
                    bad++;
                    $display("[TB] FAIL line_wrap got=(%0d,%0d) exp=(0,%0d)", df_hcount, df_vcount, pv + 11'd1);
                end
            end
        end
        total++;
        if (hs_cnt != 128 || wraps != 1) begin
            bad++;
            $display("[TB] FAIL hsync_width got=%0d wraps=%0d exp=128 wraps=1", hs_cnt, wraps);
        end
    endtask

    task automatic test_frame;
        exp_t e;
        int   w1, w2, vs_cnt, vb_cnt;
        logic [10:0] ph, pv;
        w1 = -1; w2 = -1; vs_cnt = 0; vb_cnt = 0;
        for (int i = 0; i < 3 * S_FRAME && w2 < 0; i++) begin
            ph = sm_hcount; pv = sm_vcount;
            drive_cycle(1'b0);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL frame_scan got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
            if (ph == 11'(S_HT - 1) && pv == 11'(S_VT - 1)) begin
                total++;
                if (sm_hcount !== 11'd0 || sm_vcount !== 11'd0) begin
                    bad++;
                    $display("[TB] FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", sm_hcount, sm_vcount);
                end
                if (w1 < 0) w1 = i;
                else        w2 = i;
            end else if (w1 >= 0) begin
                if (sm_vsync) vs_cnt++;
                if (sm_vblnk) vb_cnt++;
            end
        end
        total++;
        if (w2 < 0 || (w2 - w1) != S_FRAME) begin
            bad++;
            $display("[TB] FAIL frame_period got=%0d exp=%0d", w2 - w1, S_FRAME);
        end
        total++;
        if (vs_cnt != S_VS * S_HT || vb_cnt != (S_VT - S_VV) * S_HT) begin
            bad++;
            $display("[TB] FAIL vflag_len got=%0d/%0d exp=%0d/%0d", vs_cnt, vb_cnt, S_VS * S_HT, (S_VT - S_VV) * S_HT);
        end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        for (int i = 0; i < 2 * S_FRAME && !(mh == 20 && mv == 10); i++) begin
            drive_cycle(1'b0);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL mid_run got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
        end
        total++;
        if (sm_hcount !== 11'd20 || sm_vcount !== 11'd10 || sm_vsync !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_reach got=(%0d,%0d,vs=%b) exp=(20,10,vs=1)", sm_hcount, sm_vcount, sm_vsync);
        end
        drive_cycle(1'b1);
        e = sbq.pop_front();
        total++;
        if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
            bad++;
            $display("[TB] FAIL mid_reset got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
        end
        total++;
        if (obs_sm[SMW-1:SMW-26] !== 26'd0 || obs_p0 !== 26'b1010) begin
            bad++;
            $display("[TB] FAIL mid_reset_flags got=%h/%h exp=0/a", obs_sm[SMW-1:SMW-26], obs_p0);
        end
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL mid_restart got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
        end
    endtask

    task automatic test_polarity;
        exp_t e;
        int   lo_cnt;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL pol_reset got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
        end
        total++;
        if (p0_hsync !== 1'b1 || p0_vsync !== 1'b1 || sm_hsync !== 1'b0 || sm_vsync !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pol_idle got=%b%b/%b%b exp=11/00", p0_hsync, p0_vsync, sm_hsync, sm_vsync);
        end
        lo_cnt = 0;
        for (int i = 0; i < S_HT; i++) begin
            drive_cycle(1'b0);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL pol_line got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
            if (!p0_hsync) lo_cnt++;
        end
        total++;
        if (lo_cnt != S_HS) begin
            bad++;
            $display("[TB] FAIL pol_hsync_low got=%0d exp=%0d", lo_cnt, S_HS);
        end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt;
        exp_t e;
        int   pulses;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL fc_reset got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
        end
        pulses = 0;
        for (int i = 0; i < 3 * S_FRAME; i++) begin
            drive_cycle(1'b0);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL fc_run got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
            if (sm_fs) pulses++;
        end
        total++;
        if (pulses != 3 || sm_fc !== 16'd3) begin
            bad++;
            $display("[TB] FAIL fc_three got=%0d/%0d exp=3/3", pulses, sm_fc);
        end
        force u_sm.r_frame_cnt = 16'hFFFF;
        #1;
        release u_sm.r_frame_cnt;
        mfc = 16'hFFFF;
        for (int i = 0; i < S_FRAME; i++) begin
            drive_cycle(1'b0);
            e = sbq.pop_front();
            total++;
            if ({obs_sm, obs_p0, obs_df} !== {e.sm, e.p0, e.df}) begin
                bad++;
                $display("[TB] FAIL fc_wrap_run got=%h/%h/%h exp=%h/%h/%h", obs_sm, obs_p0, obs_df, e.sm, e.p0, e.df);
            end
        end
        total++;
        if (sm_fc !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL fc_wrap got=%h exp=0000", sm_fc);
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        total = 0;
        bad   = 0;
        mh = 0; mv = 0; dh = 0; dv = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
        mfs = 1'b0; mfc = 16'd0;
`endif
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        test_polarity();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
